// File: rtl/alu_ctrl_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_mc_pkg
// Description : Shared definitions for the ALU control block: ALU operation
//               codes, the sequencing FSM state encoding, and a small
//               helper used to size the busy counter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_mc_pkg;

    // ALU operation codes (4 bits; the top zero-extends to CTRL_W).
    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_slt  = 4'b0101;
    localparam logic [3:0] c_alu_sltu = 4'b0110;
    localparam logic [3:0] c_alu_sll  = 4'b0111;
    localparam logic [3:0] c_alu_srl  = 4'b1000;
    localparam logic [3:0] c_alu_sra  = 4'b1001;
    localparam logic [3:0] c_alu_mdu  = 4'b1010;

    // Sequencing FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Larger of two cycle counts; sizes the shared busy counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : alu_ctrl_mc_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Purely combinational ALU operation decoder. Maps the main
//               decoder class (aluOp), funct3 and funct7 bits to a 4-bit ALU
//               operation code, and flags M-extension (multiply/divide)
//               instructions.
// Ports       : i_alu_op [1:0] main decoder class
//               i_f3     [2:0] funct3
//               i_op           opcode bit 5 (1 = R-type)
//               i_f7_5         funct7 bit 5
//               i_f7_0         funct7 bit 0 (M-extension marker)
//               o_code   [3:0] ALU operation code
//               o_m_op         instruction is a multiply/divide/remainder
// Config      : ALU_CTRL_MEXT_EN - when defined, o_m_op is decoded from
//               funct7 bit 0; otherwise o_m_op is 0 and i_f7_0 is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_ctrl_mc_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_f3,
    input  logic       i_op,
    input  logic       i_f7_5,
    input  logic       i_f7_0,
    output logic [3:0] o_code,
    output logic       o_m_op
);

    always_comb begin
        o_code = c_alu_add;
        case (i_alu_op)
            2'b00: o_code = c_alu_add;   // loads / stores: address add
            2'b01: o_code = c_alu_sub;   // branches: compare by subtract
            2'b11: o_code = c_alu_add;
            2'b10: begin
                case (i_f3)
                    // SUB only for R-type with funct7[5]; ADDI never subtracts.
                    3'b000: o_code = (i_op && i_f7_5) ? c_alu_sub : c_alu_add;
                    3'b001: o_code = c_alu_sll;
                    3'b010: o_code = c_alu_slt;
                    3'b011: o_code = c_alu_sltu;
                    3'b100: o_code = c_alu_xor;
                    // funct7[5] selects arithmetic shift for both SRA and SRAI.
                    3'b101: o_code = i_f7_5 ? c_alu_sra : c_alu_srl;
                    3'b110: o_code = c_alu_or;
                    3'b111: o_code = c_alu_and;
                    default: o_code = c_alu_add;
                endcase
            end
            default: o_code = c_alu_add;
        endcase
    end

`ifdef ALU_CTRL_MEXT_EN
    assign o_m_op = (i_alu_op == 2'b10) && i_op && i_f7_0;
`else
    // Without the M extension funct7[0] carries no meaning here.
    logic w_unused_f7_0;
    assign w_unused_f7_0 = i_f7_0;
    assign o_m_op        = 1'b0;
`endif

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_mc
// Description : Registered ALU control generator with multi-cycle sequencing
//               for multiply/divide operations. Single-cycle operations are
//               decoded and presented one cycle after acceptance. M-extension
//               operations launch the multiply/divide unit, hold stall for
//               MUL_CYC or DIV_CYC cycles, then present the MDU code for one
//               cycle.
// Parameters  : CTRL_W  - width of aluControl (>= 4)
//               MUL_CYC - busy cycles for multiply (>= 1)
//               DIV_CYC - busy cycles for divide/remainder (>= 1)
// Ports       : clk, reset (synchronous, active-low)
//               valid_i, flush_i        request qualifier / abort
//               op, f7_5, f7_0, f3, aluOp  instruction fields
//               aluControl, ctrl_valid  registered ALU code and its qualifier
//               stall                   multi-cycle operation in flight
//               mdu_start, mdu_op       MDU launch pulse and funct3
// Config      : ALU_CTRL_MEXT_EN - enables the multiply/divide path. When
//               undefined, f7_0 is ignored, the MUL/DIV/DONE states are
//               unreachable and stall/mdu_start/mdu_op stay 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_mc
    import alu_ctrl_mc_pkg::*;
#(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_CYC = 4,
    parameter int unsigned DIV_CYC = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              op,
    input  logic              f7_5,
    input  logic              f7_0,
    input  logic [2:0]        f3,
    input  logic [1:0]        aluOp,
    output logic [CTRL_W-1:0] aluControl,
    output logic              ctrl_valid,
    output logic              stall,
    output logic              mdu_start,
    output logic [2:0]        mdu_op
);

    // Counter sized to hold the longest load value without wrapping.
    localparam int unsigned c_cnt_w = $clog2(max_u(MUL_CYC, DIV_CYC) + 1);

    // The load value is one less than the busy length: the cycle in which the
    // counter reads 0 is the last busy cycle, and DONE follows it.
    localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [3:0] w_code;
    logic       w_m_op;

    alu_op_decode u_decode (
        .i_alu_op (aluOp),
        .i_f3     (f3),
        .i_op     (op),
        .i_f7_5   (f7_5),
        .i_f7_0   (f7_0),
        .o_code   (w_code),
        .o_m_op   (w_m_op)
    );

    // ------------------------------------------------------------------
    // Sequencing FSM and output registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_cnt_w-1:0]  r_count;
    logic [CTRL_W-1:0]   r_alu_control;
    logic                r_ctrl_valid;
    logic                r_stall;
    logic                r_mdu_start;
    logic [2:0]          r_mdu_op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_alu_control <= '0;
            r_ctrl_valid  <= 1'b0;
            r_stall       <= 1'b0;
            r_mdu_start   <= 1'b0;
            r_mdu_op      <= 3'b000;
        end else if (flush_i) begin
            // Abort takes priority over any request presented this cycle.
            // aluControl is left as-is; ctrl_valid=0 marks it stale.
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_ctrl_valid <= 1'b0;
            r_stall      <= 1'b0;
            r_mdu_start  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mdu_start <= 1'b0;
                    if (valid_i && w_m_op) begin
                        // Launch the MDU; funct3[2] separates div/rem from mul.
                        r_mdu_start  <= 1'b1;
                        r_mdu_op     <= f3;
                        r_stall      <= 1'b1;
                        r_ctrl_valid <= 1'b0;
                        if (f3[2]) begin
                            r_state <= ST_DIV;
                            r_count <= c_div_load;
                        end else begin
                            r_state <= ST_MUL;
                            r_count <= c_mul_load;
                        end
                    end else if (valid_i) begin
                        r_alu_control <= CTRL_W'(w_code);
                        r_ctrl_valid  <= 1'b1;
                    end else begin
                        r_ctrl_valid  <= 1'b0;
                    end
                end

                ST_MUL, ST_DIV: begin
                    // New requests are ignored while the MDU is busy.
                    r_mdu_start <= 1'b0;
                    if (r_count == '0) begin
                        r_state       <= ST_DONE;
                        r_alu_control <= CTRL_W'(c_alu_mdu);
                        r_ctrl_valid  <= 1'b1;
                        r_stall       <= 1'b0;
                    end else begin
                        r_count <= r_count - c_cnt_one;
                    end
                end

                ST_DONE: begin
                    // The MDU result code has been visible for one cycle.
                    r_state      <= ST_IDLE;
                    r_ctrl_valid <= 1'b0;
                    r_mdu_start  <= 1'b0;
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_count      <= '0;
                    r_ctrl_valid <= 1'b0;
                    r_stall      <= 1'b0;
                    r_mdu_start  <= 1'b0;
                end
            endcase
        end
    end

    assign aluControl = r_alu_control;
    assign ctrl_valid = r_ctrl_valid;
    assign stall      = r_stall;
    assign mdu_start  = r_mdu_start;
    assign mdu_op     = r_mdu_op;

endmodule : alu_ctrl_mc
`default_nettype wire

// File: tb/tb_alu_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_mc
// Description : Directed self-checking bench for alu_ctrl_mc. Expected values
//               are hand-derived from the operation code table.
// Config      : ALU_CTRL_MEXT_EN selects the multiply/divide scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_mc;

    logic       clk;
    logic       reset;
    logic       valid_i;
    logic       flush_i;
    logic       op;
    logic       f7_5;
    logic       f7_0;
    logic [2:0] f3;
    logic [1:0] aluOp;
    logic [3:0] aluControl;
    logic       ctrl_valid;
    logic       stall;
    logic       mdu_start;
    logic [2:0] mdu_op;

    int n_chk;
    int n_err;

    alu_ctrl_mc #(
        .CTRL_W  (4),
        .MUL_CYC (4),
        .DIV_CYC (32)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .flush_i    (flush_i),
        .op         (op),
        .f7_5       (f7_5),
        .f7_0       (f7_0),
        .f3         (f3),
        .aluOp      (aluOp),
        .aluControl (aluControl),
        .ctrl_valid (ctrl_valid),
        .stall      (stall),
        .mdu_start  (mdu_start),
        .mdu_op     (mdu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f,
                         input logic o, input logic s5, input logic s0);
        valid_i = v;
        aluOp   = aop;
        f3      = f;
        op      = o;
        f7_5    = s5;
        f7_0    = s0;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ac, input logic cv,
                              input logic st, input logic ms);
        check_val({tag, ".ac"}, 32'(aluControl), 32'(ac));
        check_val({tag, ".cv"}, 32'(ctrl_valid), 32'(cv));
        check_val({tag, ".stall"}, 32'(stall), 32'(st));
        check_val({tag, ".start"}, 32'(mdu_start), 32'(ms));
    endtask

    logic [3:0] exp_sweep [8];

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_sweep = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};

        reset   = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        check_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        check_val("reset.mdu_op", 32'(mdu_op), 32'd0);
        reset = 1'b1;

        // R-type SUB, latency 1
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 1'b0);
        tick;
        check_outs("sub", 4'h1, 1'b1, 1'b0, 1'b0);

        // No request: valid drops, code holds
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("hold", 4'h1, 1'b0, 1'b0, 1'b0);

        // Class codes from aluOp
        drive(1'b1, 2'b00, 3'b101, 1'b1, 1'b1, 1'b0);
        tick;
        check_outs("aluop00", 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 3'b111, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("aluop01", 4'h1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 3'b001, 1'b1, 1'b1, 1'b0);
        tick;
        check_outs("aluop11", 4'h0, 1'b1, 1'b0, 1'b0);

        // I-type with funct7[5] set must not subtract; R-type without it adds.
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
        tick;
        check_outs("addi_f75", 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0);
        tick;
        check_outs("add_r", 4'h0, 1'b1, 1'b0, 1'b0);

        // funct3 sweep, op=0, f7_5=0
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b10, 3'(i), 1'b0, 1'b0, 1'b0);
            tick;
            check_outs($sformatf("sweep%0d", i), exp_sweep[i], 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 1'b0);
        tick;
        check_outs("srai", 4'h9, 1'b1, 1'b0, 1'b0);

        // Flush beats a simultaneous request; code holds
        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
        flush_i = 1'b1;
        tick;
        check_outs("flush_v", 4'h9, 1'b0, 1'b0, 1'b0);
        flush_i = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;

`ifdef ALU_CTRL_MEXT_EN
        // MUL (MULHU, f3=011): start pulse, 4 stall cycles, MDU on cycle 5
        drive(1'b1, 2'b10, 3'b011, 1'b1, 1'b0, 1'b1);
        tick;
        check_outs("mul.c1", 4'h9, 1'b0, 1'b1, 1'b1);
        check_val("mul.mdu_op", 32'(mdu_op), 32'd3);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick;
            check_outs($sformatf("mul.c%0d", c), 4'h9, 1'b0, 1'b1, 1'b0);
        end
        tick;
        check_outs("mul.c5", 4'hA, 1'b1, 1'b0, 1'b0);
        tick;
        check_outs("mul.c6", 4'hA, 1'b0, 1'b0, 1'b0);

        // DIV (f3=100) with requests during busy that must be ignored
        drive(1'b1, 2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        tick;
        check_outs("div.c1", 4'hA, 1'b0, 1'b1, 1'b1);
        check_val("div.mdu_op", 32'(mdu_op), 32'd4);
        for (int c = 2; c <= 33; c++) begin
            if (c == 5 || c == 20)
                drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
            else
                drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
            tick;
            if (c <= 32) begin
                check_val($sformatf("div.c%0d.cv", c), 32'(ctrl_valid), 32'd0);
                check_val($sformatf("div.c%0d.stall", c), 32'(stall), 32'd1);
            end else begin
                check_outs("div.c33", 4'hA, 1'b1, 1'b0, 1'b0);
            end
        end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        check_val("div.c34.cv", 32'(ctrl_valid), 32'd0);

        // DIV (f3=110) flushed at cycle 10
        drive(1'b1, 2'b10, 3'b110, 1'b1, 1'b0, 1'b1);
        tick;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 9; c++) tick;
        check_val("dflush.c9.stall", 32'(stall), 32'd1);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        check_outs("dflush", 4'hA, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            tick;
            check_val("dflush.quiet", 32'(ctrl_valid | stall), 32'd0);
        end
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("dflush.add", 4'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-MUL with a request present
        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 2'b10, 3'b001, 1'b1, 1'b0, 1'b1);
        tick;
        check_val("mrst.pre_stall", 32'(stall), 32'd1);
        tick;
        reset = 1'b0;
        tick;
        check_outs("mrst", 4'h0, 1'b0, 1'b0, 1'b0);
        check_val("mrst.mdu_op", 32'(mdu_op), 32'd0);
        reset = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("mrst.after", 4'h0, 1'b0, 1'b0, 1'b0);
`else
        // Without the M extension an M-shaped instruction decodes normally
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
        tick;
        check_outs("nom.add", 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        tick;
        check_outs("nom.xor", 4'h4, 1'b1, 1'b0, 1'b0);
        check_val("nom.mdu_op", 32'(mdu_op), 32'd0);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick;
            check_val("nom.stall", 32'(stall), 32'd0);
        end

        // Reset with a request present clears everything
        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("rst.pre", 4'h1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick;
        check_outs("rst", 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("rst.after", 4'h0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_alu_ctrl_mc
`default_nettype wire

// File: doc/alu_ctrl_mc.md
ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, width of aluControl (minimum 4).
REQ-002 SHALL have parameter MUL_CYC, default 4, busy cycles for multiply (minimum 1).
REQ-003 SHALL have parameter DIV_CYC, default 32, busy cycles for divide/remainder (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 valid_i  input  1  decode request qualifier.
REQ-007 flush_i  input  1  abort any in-flight operation.
REQ-008 op  input  1  opcode bit 5 (1 = R-type).
REQ-009 f7_5, f7_0  input  1 each  funct7 bits 5 and 0.
REQ-010 f3  input  3  funct3.
REQ-011 aluOp  input  2  main-decoder class.
REQ-012 aluControl  output  CTRL_W  registered ALU operation code.
REQ-013 ctrl_valid  output  1  aluControl valid this cycle.
REQ-014 stall  output  1  high while a multi-cycle operation is in flight.
REQ-015 mdu_start  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-016 mdu_op  output  3  registered f3 of the M operation.

Function
REQ-017 Codes SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, MDU 1010; zero-extended to CTRL_W.
REQ-018 aluOp 00 -> ADD; 01 -> SUB; 11 -> ADD.
REQ-019 aluOp 10: f3 000 -> SUB iff {op,f7_5}=11 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA iff f7_5 else SRL; 110 OR; 111 AND.
REQ-020 M-op SHALL be aluOp=10, op=1, f7_0=1 (MEXT_EN only).
REQ-021 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-022 IDLE, valid_i=1, non-M-op: aluControl and ctrl_valid=1 registered next cycle (latency 1); stays IDLE.
REQ-023 IDLE, valid_i=0: ctrl_valid=0 next cycle; aluControl holds.
REQ-024 IDLE, valid_i=1, M-op: mdu_start=1 and mdu_op=f3 next cycle; stall=1; enter MUL if f3[2]=0 else DIV; counter loaded MUL_CYC-1 or DIV_CYC-1.
REQ-025 MUL/DIV: stall=1, counter decrements each cycle; valid_i ignored; at counter 0 go to DONE.
REQ-026 DONE: aluControl=MDU, ctrl_valid=1, stall=0 for exactly one cycle, then IDLE.
REQ-027 Total M-op latency from accept to ctrl_valid SHALL be MUL_CYC+1 or DIV_CYC+1 cycles.
REQ-028 flush_i=1 in any state: next cycle IDLE, ctrl_valid=0, stall=0, mdu_start=0; flush wins over simultaneous valid_i.
REQ-029 Counter width SHALL be $clog2(max(MUL_CYC,DIV_CYC)+1); no wrap past 0.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, aluControl=0, ctrl_valid=0, stall=0, mdu_start=0, mdu_op=0, counter=0, including mid-operation.

Configuration
REQ-031 Macro ALU_CTRL_MEXT_EN defined: M-op path per REQ-020..027 present.
REQ-032 Macro undefined: f7_0 ignored, M-op decodes per REQ-019, MUL/DIV/DONE unreachable, stall/mdu_start/mdu_op tied 0.

Structure
REQ-033 Shared package SHALL hold the aluControl code constants and FSM state encoding.
REQ-034 Combinational decode SHALL be sub-module alu_op_decode; FSM and registers in alu_ctrl_mc.

Verification
REQ-035 aluOp=10, f3=000, op=1, f7_5=1, valid_i=1 -> next cycle aluControl=0001, ctrl_valid=1.
REQ-036 Sweep all f3 with aluOp=10, op=0 -> codes per REQ-019 (f3=101, f7_5=1 -> 1001), each latency 1.
REQ-037 MEXT_EN, MUL_CYC=4: f3=000, f7_0=1, op=1 accepted -> mdu_start 1 cycle, stall 4 cycles, ctrl_valid with 1010 on cycle 5.
REQ-038 MEXT_EN, DIV_CYC=32: f3=100 M-op, valid_i pulsed during busy -> ignored, ctrl_valid on cycle 33 only.
REQ-039 DIV in flight, flush_i=1 at cycle 10 -> IDLE next cycle, stall=0, no ctrl_valid; new add accepted after.
REQ-040 reset=0 during MUL with valid_i=1 -> all outputs 0 next cycle; macro undefined: f7_0=1 M-op decodes as ADD, stall never 1.
